// File: rtl/pagerank_pkg.sv
// Shared constants for the PageRank accelerator: AXI widths, read-requester
// indices and AXI response codes.
package pagerank_pkg;

    localparam int AXI_ID_W   = 16;
    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = 512;

    localparam int RQ_VERT   = 0;
    localparam int RQ_INEDGE = 1;
    localparam int RQ_PFX    = 2;
    localparam int RQ_NUM    = 3;

    // Wide enough for any per-requester outstanding limit up to 255.
    localparam int OUT_CNT_W = 8;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

endpackage

// File: rtl/rr_arbiter.sv
// N-way arbiter: request vector to one-hot grant. RR_EN=1 gives round-robin
// starting at a rotating pointer; RR_EN=0 gives fixed lowest-index priority.
module rr_arbiter
    import pagerank_pkg::*;
#(
    parameter int N     = RQ_NUM,
    parameter bit RR_EN = 1'b1,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    assign gnt_valid = |req;

    if (RR_EN) begin : g_rr
        logic [IDX_W-1:0] ptr_q;
        logic [IDX_W-1:0] ptr_d;
        logic             found;
        int               c;

        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        always_comb begin
            gnt     = '0;
            gnt_idx = '0;
            found   = 1'b0;
            c       = 0;
            for (int i = 0; i < N; i++) begin
                c = int'(ptr_q) + i;
                if (c >= N) c = c - N;
                if (!found && req[IDX_W'(c)]) begin
                    found             = 1'b1;
                    gnt[IDX_W'(c)]    = 1'b1;
                    gnt_idx           = IDX_W'(c);
                end
            end
        end

        always_comb begin
            ptr_d = ptr_q;
            if (advance && found)
                ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) ptr_q <= '0;
            else     ptr_q <= ptr_d;
        end
    end else begin : g_fixed
        logic found;
        logic unused_ok;

        assign unused_ok = ^{clk, rst, advance};

        always_comb begin
            gnt     = '0;
            gnt_idx = '0;
            found   = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!found && req[i]) begin
                    found   = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R read port between N_REQ requesters: tags ARID with the
// requester index, caps outstanding bursts, routes R beats by RID.
// Define RD_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module axi_rd_arbiter
    import pagerank_pkg::*;
#(
    parameter int N_REQ   = RQ_NUM,
    parameter int ID_W    = AXI_ID_W,
    parameter int ADDR_W  = AXI_ADDR_W,
    parameter int DATA_W  = AXI_DATA_W,
    parameter int MAX_OUT = 8
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [N_REQ-1:0]        req_arvalid,
    output logic [N_REQ-1:0]        req_arready,
    input  logic [N_REQ*ID_W-1:0]   req_arid,
    input  logic [N_REQ*ADDR_W-1:0] req_araddr,
    input  logic [N_REQ*8-1:0]      req_arlen,
    input  logic [N_REQ*3-1:0]      req_arsize,

    output logic [N_REQ-1:0]  req_rvalid,
    input  logic [N_REQ-1:0]  req_rready,
    output logic [ID_W-1:0]   req_rid,
    output logic [DATA_W-1:0] req_rdata,
    output logic [1:0]        req_rresp,
    output logic              req_rlast,

    output logic [ID_W-1:0]   arid_m,
    output logic [ADDR_W-1:0] araddr_m,
    output logic [7:0]        arlen_m,
    output logic [2:0]        arsize_m,
    output logic              arvalid_m,
    input  logic              arready_m,

    input  logic [ID_W-1:0]   rid_m,
    input  logic [DATA_W-1:0] rdata_m,
    input  logic [1:0]        rresp_m,
    input  logic              rlast_m,
    input  logic              rvalid_m,
    output logic              rready_m,

    output logic busy,
    output logic rid_err
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [OUT_CNT_W-1:0] MAX_OUT_C = OUT_CNT_W'(MAX_OUT);
`ifdef RD_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic              arvalid_q, arvalid_d;
    logic [ID_W-1:0]   arid_q,    arid_d;
    logic [ADDR_W-1:0] araddr_q,  araddr_d;
    logic [7:0]        arlen_q,   arlen_d;
    logic [2:0]        arsize_q,  arsize_d;
    logic              rid_err_q, rid_err_d;

    logic [OUT_CNT_W-1:0] out_cnt_q [N_REQ];
    logic [OUT_CNT_W-1:0] out_cnt_d [N_REQ];

    logic              load;
    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_valid;
    logic [IDX_W-1:0]  rid_idx;
    logic [N_REQ-1:0]  rid_hit;
    logic [N_REQ-1:0]  r_done;
    logic              unused_arid_low;

    assign load = !arvalid_q || arready_m;

    always_comb begin
        elig = '0;
        for (int g = 0; g < N_REQ; g++)
            elig[g] = req_arvalid[g] && (out_cnt_q[g] < MAX_OUT_C);
    end

    rr_arbiter #(
        .N     (N_REQ),
        .RR_EN (RR_EN),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (elig),
        .advance   (load),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // The AR register only reloads once the current beat has been accepted.
    always_comb begin
        arvalid_d   = arvalid_q;
        arid_d      = arid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arsize_d    = arsize_q;
        req_arready = '0;
        if (load) begin
            arvalid_d = gnt_valid;
            if (gnt_valid) begin
                req_arready = gnt;
                for (int g = 0; g < N_REQ; g++) begin
                    if (gnt[g]) begin
                        arid_d   = {req_arid[g*ID_W+IDX_W +: ID_W-IDX_W], gnt_idx};
                        araddr_d = req_araddr[g*ADDR_W +: ADDR_W];
                        arlen_d  = req_arlen[g*8 +: 8];
                        arsize_d = req_arsize[g*3 +: 3];
                    end
                end
            end
        end
    end

    always_comb begin
        unused_arid_low = 1'b0;
        for (int g = 0; g < N_REQ; g++)
            unused_arid_low = unused_arid_low ^ (^req_arid[g*ID_W +: IDX_W]);
    end

    // Stateless R steering; beats whose RID index names no requester are drained.
    always_comb begin
        rid_idx    = rid_m[IDX_W-1:0];
        rid_hit    = '0;
        req_rvalid = '0;
        rready_m   = 1'b1;
        for (int g = 0; g < N_REQ; g++) begin
            if (rid_idx == IDX_W'(g)) begin
                rid_hit[g]    = 1'b1;
                req_rvalid[g] = rvalid_m;
                rready_m      = req_rready[g];
            end
        end
    end

    assign req_rid   = rid_m;
    assign req_rdata = rdata_m;
    assign req_rresp = rresp_m;
    assign req_rlast = rlast_m;

    always_comb begin
        r_done = '0;
        for (int g = 0; g < N_REQ; g++) begin
            r_done[g]    = rvalid_m && rready_m && rlast_m && rid_hit[g];
            out_cnt_d[g] = out_cnt_q[g];
            if (req_arready[g] && !r_done[g])
                out_cnt_d[g] = out_cnt_q[g] + 1'b1;
            else if (!req_arready[g] && r_done[g] && out_cnt_q[g] != '0)
                out_cnt_d[g] = out_cnt_q[g] - 1'b1;
        end
    end

    assign rid_err_d = rid_err_q || (rvalid_m && !(|rid_hit));

    always_comb begin
        busy = arvalid_q;
        for (int g = 0; g < N_REQ; g++)
            if (out_cnt_q[g] != '0) busy = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            rid_err_q <= 1'b0;
            // NOTE: the counter array is reset because it gates eligibility; a stale count would block a requester.
            for (int g = 0; g < N_REQ; g++) out_cnt_q[g] <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            rid_err_q <= rid_err_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign arvalid_m = arvalid_q;
    assign arid_m    = arid_q;
    assign araddr_m  = araddr_q;
    assign arlen_m   = arlen_q;
    assign arsize_m  = arsize_q;
    assign rid_err   = rid_err_q;

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares the single AXI read channel (AR/R) of the PageRank accelerator between N_REQ read requesters: vertex fetch, in-edge fetch and old-prefix-sum fetch. Sits between those engines and the AXI memory port driven by the shell (or `axi_emu` in simulation). Arbitrates AR requests, tags each with the requester index in the low ARID bits, limits outstanding bursts per requester, and steers R beats back by RID. Write channels bypass this block.

## Interface
- N_REQ, 3, number of read requesters (2..8)
- ID_W, 16, AXI ID width
- ADDR_W, 64, address width
- DATA_W, 512, read data width
- MAX_OUT, 8, max outstanding bursts per requester (1..255)
- IDX_W, derived $clog2(N_REQ), ID bits used for routing

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_arvalid  in  N_REQ  per-requester AR valid
- req_arready  out  N_REQ  per-requester AR accept
- req_arid  in  N_REQ*ID_W  requester ID; low IDX_W bits ignored
- req_araddr  in  N_REQ*ADDR_W  burst address
- req_arlen  in  N_REQ*8  burst length − 1
- req_arsize  in  N_REQ*3  beat size
- req_rvalid  out  N_REQ  R beat valid, one-hot or zero
- req_rready  in  N_REQ  per-requester R ready
- req_rid, req_rdata, req_rresp, req_rlast  out  ID_W/DATA_W/2/1  broadcast R payload (rid_m unmodified)
- arid_m, araddr_m, arlen_m, arsize_m, arvalid_m  out  16/64/8/3/1  AXI AR master
- arready_m  in  1
- rid_m, rdata_m, rresp_m, rlast_m, rvalid_m  in  16/512/2/1/1  AXI R
- rready_m  out  1
- busy  out  1  any outstanding count nonzero or arvalid_m high
- rid_err  out  1  sticky: R beat with RID index ≥ N_REQ seen

## Operation
- AR output register (arvalid_m plus payload) loads when `load = !arvalid_m || arready_m`.
- Eligible requester g: req_arvalid[g] && out_cnt[g] < MAX_OUT.
- When load and ≥1 eligible: grant one (policy per Configuration), req_arready[g]=1 that cycle only; register payload with arid_m = {req_arid[g][ID_W-1:IDX_W], g}.
- When load and none eligible: arvalid_m ← 0.
- out_cnt[g] +1 on grant; −1 on R beat with rvalid_m && rready_m && rlast_m && rid_m[IDX_W-1:0]==g; both same cycle → unchanged; decrement at 0 holds 0.
- R routing is stateless: t = rid_m[IDX_W-1:0]; req_rvalid[t]=rvalid_m, rready_m=req_rready[t].
- t ≥ N_REQ: beat consumed (rready_m=1), no req_rvalid asserted, rid_err set until rst.
- Reset: arvalid_m=0, payload 0, all out_cnt=0, rr pointer=0, rid_err=0, busy=0. Responses arriving after a mid-burst reset are still routed; counters saturate at 0.

## Timing
- AR: requester handshake cycle N → arvalid_m high at N+1; sustained 1 AR/cycle while arready_m high.
- arvalid_m never drops and payload never changes until arready_m (AXI rule).
- R: combinational pass-through, zero latency; req_rready to rready_m combinational.
- req_arready depends combinationally on arready_m and req_arvalid; requesters must not make arvalid depend on arready.

## Configuration
- RD_ARB_RR_EN defined: round-robin; pointer advances to grant+1 (mod N_REQ) after each grant; search starts at pointer.
- Undefined: fixed priority, lowest index wins; pointer logic absent.

## Structure
- Shared package `pagerank_pkg`: AXI widths (ID/ADDR/DATA), requester index constants (RQ_VERT=0, RQ_INEDGE=1, RQ_PFX=2), AXI resp codes.
- One sub-module `rr_arbiter` (N-wide request vector → one-hot grant, advance input), used under both policies with fixed mode when RD_ARB_RR_EN undefined.

## Test plan
- Single requester 1 issues araddr 0xA0, arlen 0, arready_m=1 → arvalid_m at next cycle with arid_m low bits 1; R beat rid 1 → only req_rvalid[1], out_cnt[1] 1→0.
- All three requesters assert continuously, arready_m=1, RR enabled → grants 0,1,2,0,1,2; fixed prio build → requester 0 every cycle.
- arready_m held low 5 cycles → arvalid_m and araddr_m stable, no req_arready asserted.
- Requester 0 issues MAX_OUT=8 bursts with no responses → 9th not granted, requester 2 still granted; one rlast beat to 0 → requester 0 granted next load.
- rid_m low bits = 3 (N_REQ=3) with rvalid_m → rready_m=1, req_rvalid=0, rid_err=1 until rst.
- rst asserted with 4 outstanding and arvalid_m high → next cycle arvalid_m=0, busy=0, counts 0; late rlast beat does not underflow.
